// File: rtl/startup_seq_pkg.sv
// Shared types and helpers for the power-up sequencer.
//   state_e        : sequencer FSM states
//   stage_delay_at : pulls one stage's delay out of the packed delay vector
package startup_seq_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } state_e;

  // Upper bounds on the parameters the sequencer accepts
  localparam int unsigned MAX_STAGES     = 16;
  localparam int unsigned MAX_CNT_W      = 64;
  localparam int unsigned MAX_DELAY_BITS = MAX_STAGES * MAX_CNT_W;

  // Returns bits [idx*cnt_w +: cnt_w] of vec, zero-extended to MAX_CNT_W
  function automatic logic [MAX_CNT_W-1:0] stage_delay_at(
    input logic [MAX_DELAY_BITS-1:0] vec,
    input int unsigned               idx,
    input int unsigned               cnt_w
  );
    logic [MAX_DELAY_BITS-1:0] shifted;
    logic [MAX_CNT_W-1:0]      mask;
    shifted = vec >> (idx * cnt_w);
    if (cnt_w >= MAX_CNT_W) begin
      mask = '1;
    end else begin
      mask = (MAX_CNT_W'(1) << cnt_w) - MAX_CNT_W'(1);
    end
    return MAX_CNT_W'(shifted) & mask;
  endfunction

endpackage

// File: rtl/startup_stage_timer.sv
// Per-stage delay timer: counts unheld cycles and strobes when the count
// reaches the programmed delay, clearing itself on that same edge.
//   clock_i     : system clock, rising edge
//   reset_i     : asynchronous active-high reset
//   clear_i     : synchronous clear (highest priority)
//   enable_i    : count / compare enable
//   delay_i     : delay for the stage currently timing
//   expired_c_o : combinational strobe, count >= delay while enabled
module startup_stage_timer #(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 clear_i,
  input  logic                 enable_i,
  input  logic [CNT_WIDTH-1:0] delay_i,
  output logic                 expired_c_o
);

  logic [CNT_WIDTH-1:0] count_q;
  logic [CNT_WIDTH-1:0] count_d;

  // >= rather than == so a delay lowered below the count still completes
  always_comb begin
    expired_c_o = enable_i && (count_q >= delay_i);
  end

  // Counter never wraps: it is cleared as soon as it reaches the delay
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (expired_c_o) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/startup_sequencer.sv
// Power-up sequencer: releases NUM_STAGES ready flags in ascending order,
// each after its own programmable delay from the previous release.
//   clock_i       : system clock, rising edge
//   reset_i       : asynchronous active-high reset
//   restart_i     : synchronous pulse, restarts from stage 0 (beats hold_i)
//   hold_i        : level, freezes counting and stage advance while in RUN
//   stage_delay_i : packed delays, stage k at [k*CNT_WIDTH +: CNT_WIDTH]
//   ready_o       : thermometer release flags, bit 0 first
//   done_o        : all stages released
//   busy_o        : sequence in progress
//   stage_o       : stage currently timing, NUM_STAGES once complete
module startup_sequencer
  import startup_seq_pkg::*;
#(
  parameter  int unsigned NUM_STAGES = 4,
  parameter  int unsigned CNT_WIDTH  = 32,
  localparam int unsigned STAGE_W    = $clog2(NUM_STAGES + 1)
) (
  input  logic                            clock_i,
  input  logic                            reset_i,
  input  logic                            restart_i,
  input  logic                            hold_i,
  input  logic [NUM_STAGES*CNT_WIDTH-1:0] stage_delay_i,
  output logic [NUM_STAGES-1:0]           ready_o,
  output logic                            done_o,
  output logic                            busy_o,
  output logic [STAGE_W-1:0]              stage_o
);

  state_e                state_q;
  state_e                state_d;
  logic [NUM_STAGES-1:0] ready_q;
  logic [NUM_STAGES-1:0] ready_d;
  logic [STAGE_W-1:0]    stage_q;
  logic [STAGE_W-1:0]    stage_d;
  logic                  done_q;
  logic                  done_d;
  logic                  busy_q;
  logic                  busy_d;

  logic                  timer_en;
  logic                  expired;
  logic                  last_stage;
  logic [CNT_WIDTH-1:0]  cur_delay;

  // Delay is sampled live each cycle; only meaningful while in RUN
  always_comb begin
    cur_delay = CNT_WIDTH'(stage_delay_at(MAX_DELAY_BITS'(stage_delay_i),
                                          int'(stage_q), CNT_WIDTH));
  end

  always_comb begin
    timer_en   = (state_q == ST_RUN) && !hold_i && !restart_i;
    last_stage = (stage_q == STAGE_W'(NUM_STAGES - 1));
  end

  startup_stage_timer #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_timer (
    .clock_i     (clock_i),
    .reset_i     (reset_i),
    .clear_i     (restart_i),
    .enable_i    (timer_en),
    .delay_i     (cur_delay),
    .expired_c_o (expired)
  );

  // State register plus the registered outputs
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_RUN;
      ready_q <= '0;
      stage_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      stage_q <= stage_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (!restart_i && expired && last_stage) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (restart_i) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Output next values; done/busy follow the next state so they stay registered
  always_comb begin
    ready_d = ready_q;
    stage_d = stage_q;
    if (restart_i) begin
      ready_d = '0;
      stage_d = '0;
    end else if (expired) begin
      ready_d = ready_q | (NUM_STAGES'(1) << stage_q);
      stage_d = stage_q + STAGE_W'(1);
    end
    done_d = (state_d == ST_DONE);
    busy_d = (state_d == ST_RUN);
  end

  assign ready_o = ready_q;
  assign stage_o = stage_q;
  assign done_o  = done_q;
  assign busy_o  = busy_q;

endmodule

// File: tb/tb_startup_sequencer.sv
// Directed bench for startup_sequencer: a 4-stage / 32-bit instance and a
// 1-stage / 8-bit instance for the full-range delay case.
module tb_startup_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 4-stage instance
  logic         reset   = 1'b1;
  logic         restart = 1'b0;
  logic         hold    = 1'b0;
  logic [127:0] delays  = {32'd2, 32'd5, 32'd0, 32'd3};
  logic [3:0]   ready;
  logic         done;
  logic         busy;
  logic [2:0]   stage;

  // 1-stage instance
  logic         s_reset   = 1'b1;
  logic         s_restart = 1'b0;
  logic         s_hold    = 1'b0;
  logic [7:0]   s_delay   = 8'd255;
  logic [0:0]   s_ready;
  logic         s_done;
  logic         s_busy;
  logic [0:0]   s_stage;

  int n_cmp = 0;
  int n_err = 0;

  startup_sequencer #(.NUM_STAGES(4), .CNT_WIDTH(32)) dut (
    .clock_i       (clk),
    .reset_i       (reset),
    .restart_i     (restart),
    .hold_i        (hold),
    .stage_delay_i (delays),
    .ready_o       (ready),
    .done_o        (done),
    .busy_o        (busy),
    .stage_o       (stage)
  );

  startup_sequencer #(.NUM_STAGES(1), .CNT_WIDTH(8)) dut_small (
    .clock_i       (clk),
    .reset_i       (s_reset),
    .restart_i     (s_restart),
    .hold_i        (s_hold),
    .stage_delay_i (s_delay),
    .ready_o       (s_ready),
    .done_o        (s_done),
    .busy_o        (s_busy),
    .stage_o       (s_stage)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected thermometer after n edges, given each bit's release edge
  function automatic logic [3:0] exp_ready(input int n, input int t0, input int t1,
                                           input int t2, input int t3);
    logic [3:0] r;
    r[0] = (n >= t0);
    r[1] = (n >= t1);
    r[2] = (n >= t2);
    r[3] = (n >= t3);
    return r;
  endfunction

  // Expected {ready, stage, done, busy} for a given ready pattern
  function automatic logic [8:0] exp_tuple(input logic [3:0] r);
    logic [2:0] cnt;
    cnt = 3'(r[0]) + 3'(r[1]) + 3'(r[2]) + 3'(r[3]);
    return {r, cnt, (r == 4'b1111), (r != 4'b1111)};
  endfunction

  // Leaves reset released just after a rising edge; the next edge is edge 1
  task automatic do_reset();
    reset   = 1'b1;
    restart = 1'b0;
    hold    = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    n_cmp++;
    if ({ready, stage, done, busy} !== 9'b0000_000_0_1) begin
      n_err++;
      $display("FAIL reset_state: got %b expected %b", {ready, stage, done, busy}, 9'b0000_000_0_1);
    end
  endtask

  task automatic test_nominal();
    logic [8:0] e;
    do_reset();
    for (int n = 1; n <= 15; n++) begin
      step();
      e = exp_tuple(exp_ready(n, 4, 5, 11, 14));
      n_cmp++;
      if ({ready, stage, done, busy} !== e) begin
        n_err++;
        $display("FAIL nominal edge %0d: got %b expected %b", n, {ready, stage, done, busy}, e);
      end
    end
  endtask

  task automatic test_hold();
    logic [8:0] e;
    do_reset();
    // Stage 2 has counter=2 after edge 7; edges 8..17 are held
    for (int n = 1; n <= 25; n++) begin
      if (n == 8)  hold = 1'b1;
      if (n == 18) hold = 1'b0;
      step();
      e = exp_tuple(exp_ready(n, 4, 5, 21, 24));
      n_cmp++;
      if ({ready, stage, done, busy} !== e) begin
        n_err++;
        $display("FAIL hold edge %0d: got %b expected %b", n, {ready, stage, done, busy}, e);
      end
    end
  endtask

  task automatic test_restart();
    logic [8:0] e;
    do_reset();
    repeat (9) step();
    n_cmp++;
    if (ready !== 4'b0011) begin
      n_err++;
      $display("FAIL restart_pre: got %b expected %b", ready, 4'b0011);
    end
    restart = 1'b1;
    step();
    restart = 1'b0;
    n_cmp++;
    if ({ready, stage, done, busy} !== 9'b0000_000_0_1) begin
      n_err++;
      $display("FAIL restart_clear: got %b expected %b", {ready, stage, done, busy}, 9'b0000_000_0_1);
    end
    // Replay with the same relative timing
    for (int n = 1; n <= 14; n++) begin
      step();
      e = exp_tuple(exp_ready(n, 4, 5, 11, 14));
      n_cmp++;
      if ({ready, stage, done, busy} !== e) begin
        n_err++;
        $display("FAIL restart_replay edge %0d: got %b expected %b", n, {ready, stage, done, busy}, e);
      end
    end
    // hold is ignored in DONE
    hold = 1'b1;
    step();
    n_cmp++;
    if ({ready, stage, done, busy} !== 9'b1111_100_1_0) begin
      n_err++;
      $display("FAIL done_hold: got %b expected %b", {ready, stage, done, busy}, 9'b1111_100_1_0);
    end
    hold = 1'b0;
    // restart from DONE
    restart = 1'b1;
    step();
    restart = 1'b0;
    n_cmp++;
    if ({ready, stage, done, busy} !== 9'b0000_000_0_1) begin
      n_err++;
      $display("FAIL done_restart: got %b expected %b", {ready, stage, done, busy}, 9'b0000_000_0_1);
    end
    // restart together with hold mid-sequence: restart wins
    repeat (6) step();
    restart = 1'b1;
    hold    = 1'b1;
    step();
    restart = 1'b0;
    hold    = 1'b0;
    n_cmp++;
    if ({ready, stage, done, busy} !== 9'b0000_000_0_1) begin
      n_err++;
      $display("FAIL restart_with_hold: got %b expected %b", {ready, stage, done, busy}, 9'b0000_000_0_1);
    end
    for (int n = 1; n <= 5; n++) begin
      step();
      e = exp_tuple(exp_ready(n, 4, 5, 11, 14));
      n_cmp++;
      if ({ready, stage, done, busy} !== e) begin
        n_err++;
        $display("FAIL restart_hold_replay edge %0d: got %b expected %b", n, {ready, stage, done, busy}, e);
      end
    end
  endtask

  task automatic test_lower_delay();
    logic [8:0] e;
    do_reset();
    // Stage 2 counter=3 after edge 8
    repeat (8) step();
    delays[64 +: 32] = 32'd1;
    for (int n = 9; n <= 12; n++) begin
      step();
      e = exp_tuple(exp_ready(n, 4, 5, 9, 12));
      n_cmp++;
      if ({ready, stage, done, busy} !== e) begin
        n_err++;
        $display("FAIL lower_delay edge %0d: got %b expected %b", n, {ready, stage, done, busy}, e);
      end
    end
    delays[64 +: 32] = 32'd5;
  endtask

  task automatic test_async_reset();
    logic [8:0] e;
    do_reset();
    repeat (6) step();
    #3;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({ready, stage, done, busy} !== 9'b0000_000_0_1) begin
      n_err++;
      $display("FAIL async_reset: got %b expected %b", {ready, stage, done, busy}, 9'b0000_000_0_1);
    end
    step();
    reset = 1'b0;
    for (int n = 1; n <= 14; n++) begin
      step();
      e = exp_tuple(exp_ready(n, 4, 5, 11, 14));
      n_cmp++;
      if ({ready, stage, done, busy} !== e) begin
        n_err++;
        $display("FAIL async_replay edge %0d: got %b expected %b", n, {ready, stage, done, busy}, e);
      end
    end
  endtask

  task automatic test_max_delay();
    step();
    s_reset = 1'b0;
    for (int n = 1; n <= 257; n++) begin
      step();
      if (n == 1 || n == 255) begin
        n_cmp++;
        if ({s_ready, s_stage, s_done, s_busy} !== 4'b0_0_0_1) begin
          n_err++;
          $display("FAIL max_delay edge %0d: got %b expected %b", n, {s_ready, s_stage, s_done, s_busy}, 4'b0001);
        end
      end
      if (n == 256 || n == 257) begin
        n_cmp++;
        if ({s_ready, s_stage, s_done, s_busy} !== 4'b1_1_1_0) begin
          n_err++;
          $display("FAIL max_delay edge %0d: got %b expected %b", n, {s_ready, s_stage, s_done, s_busy}, 4'b1110);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_hold();
    test_restart();
    test_lower_delay();
    test_async_reset();
    test_max_delay();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
